uart_packet_tx: RTL and testbench
=================================

UART_PACKET_TX -- requirements
Module: uart_packet_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 2582, clk cycles per serial bit; 2 SHALL be the minimum legal value.
REQ-002 Parameter BYTES, default 8, bytes per packet; 1 SHALL be the minimum legal value.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 tx_start  input  1  one-cycle request to send the packet on data_in.
REQ-006 data_in  input  8*BYTES  packet; byte k = data_in[8k+7:8k].
REQ-007 tx_out  output  1  serial line, 8N1, idle high.
REQ-008 busy  output  1  high from the cycle after an accepted tx_start until the done cycle.
REQ-009 done  output  1  one-cycle pulse after the last stop bit completes.
REQ-010 frame_err  output  1  one-cycle pulse on a rejected packet; exists only with TX_FRAME_CHECK_EN.

Function
REQ-011 States SHALL be IDLE, START, DATA, STOP and DONE.
REQ-012 In IDLE with tx_start=1, data_in SHALL be captured into an internal shift register, the byte index SHALL be cleared, and the state SHALL move to START.
REQ-013 tx_start SHALL be ignored outside IDLE; captured data SHALL NOT change mid-packet.
REQ-014 tx_out SHALL fall in the cycle after tx_start is accepted; latency is 1 cycle.
REQ-015 START SHALL drive 0 for CLKS_PER_BIT cycles, then move to DATA.
REQ-016 DATA SHALL drive bits 0..7 of the current byte, LSB first, each for CLKS_PER_BIT cycles, then move to STOP.
REQ-017 STOP SHALL drive 1 for CLKS_PER_BIT cycles, then:
  - byte index < BYTES-1: increment the index, move to START (no inter-byte gap);
  - otherwise: move to DONE.
REQ-018 Bytes SHALL be sent in order byte 0 (data_in[7:0]) first through byte BYTES-1.
REQ-019 DONE SHALL last exactly one cycle, assert done, drive tx_out=1, then return to IDLE.
REQ-020 A tx_start arriving in the DONE cycle SHALL be ignored; it is accepted from the next cycle in IDLE.
REQ-021 The bit-period counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 on every bit boundary; its width SHALL be $clog2(CLKS_PER_BIT).
REQ-022 Packet duration from tx_start to done SHALL be BYTES*10*CLKS_PER_BIT+1 cycles; the default is 206561 cycles.
REQ-023 tx_out SHALL come directly from a flop, with no combinational path to the pin.

Reset
REQ-024 With rst=1, regardless of clock, the following SHALL take effect immediately: state=IDLE, tx_out=1, busy=0, done=0, frame_err=0, counters=0, and shift register=0.
REQ-025 A reset mid-packet SHALL abort the packet with no done pulse; a tx_start in the first cycle after rst falls SHALL be accepted.

Configuration
REQ-026 Macro TX_FRAME_CHECK_EN defined: in IDLE, a tx_start with data_in[7:0]!=8'h02 or data_in[8*BYTES-1:8*BYTES-8]!=8'h03 SHALL be rejected:
  - frame_err pulses the next cycle;
  - tx_out stays 1;
  - busy stays 0.
REQ-027 Macro TX_FRAME_CHECK_EN undefined: every tx_start in IDLE SHALL be accepted, and the frame_err port and its logic SHALL be absent.

Verification (CLKS_PER_BIT=4, BYTES=8 unless stated)
REQ-028 Send data_in=64'h03_77_66_55_44_33_22_02 -> decoded bytes 02,22,33,44,55,66,77,03; done at cycle 321 after tx_start; busy high for cycles 1..320.
REQ-029 Pulse tx_start again at cycle 100 of a packet with different data -> waveform and done timing identical to the first packet only.
REQ-030 Assert rst at cycle 150 mid-packet -> tx_out=1 in the same cycle, no done; a new tx_start after release transmits a full packet.
REQ-031 Hold tx_start high continuously -> packets go back-to-back with one idle-high cycle (DONE) plus the acceptance cycle between them.
REQ-032 TX_FRAME_CHECK_EN defined, data_in[7:0]=8'h05 -> frame_err pulses 1 cycle, tx_out constant 1, done never asserts.
REQ-033 Default parameters, byte 0=8'hA5 -> the first falling edge sits 1 cycle after tx_start and each bit lasts exactly 2582 cycles; the bits sample as 1,0,1,0,0,1,0,1.

Source files
------------

// File: rtl/uart_packet_tx.sv
// ============================================================================
// Module      : uart_packet_tx
// Description : Sends a BYTES-long packet as back-to-back 8N1 UART frames.
//               Optional frame check (02 header / 03 trailer) under the
//               TX_FRAME_CHECK_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_packet_tx #(
   parameter int CLKS_PER_BIT = 2582,
   parameter int BYTES        = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tx_start,
   input  logic [8*BYTES-1:0] data_in,
   output logic               tx_out,
   output logic               busy,
   output logic               done
`ifdef TX_FRAME_CHECK_EN
   ,
   output logic               frame_err
`endif
);

   localparam int c_cnt_w  = $clog2(CLKS_PER_BIT);
   localparam int c_byte_w = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [c_cnt_w-1:0]  c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
   localparam logic [c_byte_w-1:0] c_byte_last = c_byte_w'(BYTES - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t               r_state;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [2:0]           r_bit_idx;
   logic [c_byte_w-1:0]  r_byte_idx;
   logic [8*BYTES-1:0]   r_shreg;

   state_t               w_state_nxt;
   logic [c_cnt_w-1:0]   w_cnt_nxt;
   logic [2:0]           w_bit_nxt;
   logic [c_byte_w-1:0]  w_byte_nxt;
   logic [8*BYTES-1:0]   w_shreg_nxt;
   logic                 w_tx_nxt;
   logic                 w_busy_nxt;
   logic                 w_done_nxt;
   logic                 w_bit_end;
   logic                 w_accept;

   assign w_bit_end = (r_cnt == c_bit_last);

`ifdef TX_FRAME_CHECK_EN
   logic w_frame_ok;
   logic w_reject;
   assign w_frame_ok = (data_in[7:0] == 8'h02) && (data_in[8*BYTES-1 -: 8] == 8'h03);
   assign w_accept   = tx_start & w_frame_ok;
   assign w_reject   = tx_start & ~w_frame_ok & (r_state == IDLE);
`else
   assign w_accept   = tx_start;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit_idx;
      w_byte_nxt  = r_byte_idx;
      w_shreg_nxt = r_shreg;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_shreg_nxt = data_in;
               w_byte_nxt  = '0;
               w_bit_nxt   = '0;
               w_cnt_nxt   = '0;
               w_state_nxt = START;
            end
         end
         START: begin
            if (w_bit_end) begin
               w_cnt_nxt   = '0;
               w_bit_nxt   = '0;
               w_state_nxt = DATA;
            end else begin
               w_cnt_nxt = r_cnt + c_cnt_w'(1);
            end
         end
         DATA: begin
            if (w_bit_end) begin
               w_cnt_nxt = '0;
               // Shifting one bit per period leaves the next byte at bit 0 after eight shifts
               w_shreg_nxt = r_shreg >> 1;
               if (r_bit_idx == 3'd7) begin
                  w_state_nxt = STOP;
               end else begin
                  w_bit_nxt = r_bit_idx + 3'd1;
               end
            end else begin
               w_cnt_nxt = r_cnt + c_cnt_w'(1);
            end
         end
         STOP: begin
            if (w_bit_end) begin
               w_cnt_nxt = '0;
               if (r_byte_idx == c_byte_last) begin
                  w_state_nxt = DONE;
               end else begin
                  w_byte_nxt  = r_byte_idx + c_byte_w'(1);
                  w_state_nxt = START;
               end
            end else begin
               w_cnt_nxt = r_cnt + c_cnt_w'(1);
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase

      // Outputs are decoded from the next state so the pins come straight from flops
      w_tx_nxt   = 1'b1;
      w_busy_nxt = 1'b0;
      w_done_nxt = 1'b0;
      case (w_state_nxt)
         START: begin
            w_tx_nxt   = 1'b0;
            w_busy_nxt = 1'b1;
         end
         DATA: begin
            w_tx_nxt   = w_shreg_nxt[0];
            w_busy_nxt = 1'b1;
         end
         STOP:    w_busy_nxt = 1'b1;
         DONE:    w_done_nxt = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_bit_idx  <= '0;
         r_byte_idx <= '0;
         r_shreg    <= '0;
         tx_out     <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_bit_idx  <= w_bit_nxt;
         r_byte_idx <= w_byte_nxt;
         r_shreg    <= w_shreg_nxt;
         tx_out     <= w_tx_nxt;
         busy       <= w_busy_nxt;
         done       <= w_done_nxt;
      end
   end

`ifdef TX_FRAME_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_err <= 1'b0;
      end else begin
         frame_err <= w_reject;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_packet_tx.sv
// Testbench for uart_packet_tx: random packets, scoreboard of expected bytes and done times.
`default_nettype none

module tb_uart_packet_tx;

   localparam int CPB = 4;
   localparam int NB  = 8;
   localparam int PKT = NB * 10 * CPB;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            tx_start = 1'b0;
   logic [8*NB-1:0] data_in = '0;
   logic            tx_out;
   logic            busy;
   logic            done;
`ifdef TX_FRAME_CHECK_EN
   logic            frame_err;
`endif

   uart_packet_tx #(.CLKS_PER_BIT(CPB), .BYTES(NB)) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_start (tx_start),
      .data_in  (data_in),
      .tx_out   (tx_out),
      .busy     (busy),
      .done     (done)
`ifdef TX_FRAME_CHECK_EN
      ,
      .frame_err(frame_err)
`endif
   );

   always #5 clk = ~clk;

   int edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   int checks = 0;
   int failures = 0;

   // Reference model state: the packet in flight and the expected output queues
   bit          cur_valid = 1'b0;
   int          cur_e = 0;
   logic [63:0] cur_d = '0;
   int          free_edge = 0;
   int          fe_edge = -10;
   logic [7:0]  exp_bytes[$];
   int          exp_done[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
      end
   endtask

   // Line level for cycle c (1-based after acceptance) derived from the 8N1 frame layout
   function automatic logic exp_line(input int c, input logic [63:0] d);
      int s, b, p;
      if (c < 1 || c > PKT) return 1'b1;
      s = (c - 1) / CPB;
      b = s / 10;
      p = s % 10;
      if (p == 0) return 1'b0;
      if (p == 9) return 1'b1;
      return d[8*b + p - 1];
   endfunction

   function automatic logic [63:0] rand_pkt();
      logic [63:0] d;
      d = {$urandom, $urandom};
`ifdef TX_FRAME_CHECK_EN
      if ($urandom_range(3) != 0) begin
         d[7:0]   = 8'h02;
         d[63:56] = 8'h03;
      end
`endif
      return d;
   endfunction

   task automatic step(input logic st, input logic [63:0] d, input logic r);
      int e;
      @(negedge clk);
      rst      = r;
      tx_start = st;
      data_in  = d;
      e = edge_n + 1;
      if (r) begin
         cur_valid = 1'b0;
         free_edge = 0;
         exp_bytes.delete();
         exp_done.delete();
      end else if (st && e >= free_edge) begin
`ifdef TX_FRAME_CHECK_EN
         if (d[7:0] != 8'h02 || d[63:56] != 8'h03) begin
            fe_edge = e;
         end else
`endif
         begin
            cur_valid = 1'b1;
            cur_e     = e;
            cur_d     = d;
            free_edge = e + PKT + 2;
            for (int k = 0; k < NB; k++) exp_bytes.push_back(d[8*k +: 8]);
            exp_done.push_back(e + PKT);
         end
      end
   endtask

   task automatic run_idle(input int n);
      repeat (n) step(1'b0, rand_pkt(), 1'b0);
   endtask

   // Monitor: cycle-exact line/busy/done model plus a UART decoder feeding the byte scoreboard
   int         c;
   int         idx;
   bit         dec_on = 1'b0;
   int         dec_t = 0;
   logic [7:0] dec_byte = '0;

   always @(posedge clk) begin
      #1;
      if (rst) begin
         dec_on = 1'b0;
      end else begin
         c = edge_n - cur_e + 1;
         if (cur_valid) begin
            chk("tx_out", tx_out, exp_line(c, cur_d));
            chk("busy", busy, (c >= 1 && c <= PKT));
            chk("done", done, (c == PKT + 1));
         end else begin
            chk("idle_tx_out", tx_out, 1);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
         end
`ifdef TX_FRAME_CHECK_EN
         chk("frame_err", frame_err, (edge_n == fe_edge));
`endif
         if (done) begin
            chk("done_queue", exp_done.size() > 0, 1);
            if (exp_done.size() > 0) chk("done_time", edge_n, exp_done.pop_front());
         end
         if (!dec_on) begin
            if (tx_out == 1'b0) begin
               dec_on = 1'b1;
               dec_t  = 0;
            end
         end else begin
            dec_t++;
            if (dec_t % CPB == CPB / 2) begin
               idx = dec_t / CPB;
               if (idx >= 1 && idx <= 8) begin
                  dec_byte[idx-1] = tx_out;
               end else if (idx == 9) begin
                  chk("stop_bit", tx_out, 1);
                  chk("byte_queue", exp_bytes.size() > 0, 1);
                  if (exp_bytes.size() > 0) chk("byte", dec_byte, exp_bytes.pop_front());
                  dec_on = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      repeat (3) step(1'b0, rand_pkt(), 1'b1);
      #1;
      chk("reset_tx_out", tx_out, 1);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);

      // Reference packet, with an ignored second request at cycle 100
      step(1'b1, 64'h0377665544332202, 1'b0);
      run_idle(99);
      step(1'b1, rand_pkt(), 1'b0);
      run_idle(240);

      // Reset at cycle 150, then a request in the first cycle after release
      step(1'b1, rand_pkt(), 1'b0);
      run_idle(149);
      step(1'b0, rand_pkt(), 1'b1);
      #1;
      chk("abort_tx_out", tx_out, 1);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      step(1'b0, rand_pkt(), 1'b1);
      step(1'b1, rand_pkt(), 1'b0);
      run_idle(330);

      // tx_start held high: back-to-back packets
      repeat (3 * (PKT + 2) + 5) step(1'b1, rand_pkt(), 1'b0);
      run_idle(330);

      // Random packets with random gaps
      repeat (4) begin
         step(1'b1, rand_pkt(), 1'b0);
         repeat ($urandom_range(PKT + 30)) step(1'b0, rand_pkt(), 1'b0);
      end
      run_idle(340);

      chk("bytes_left", exp_bytes.size(), 0);
      chk("done_left", exp_done.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
